// File: rtl/adc_mcp3008_responder.sv
// adc_mcp3008_responder: SPI mode-0 responder that emulates an MCP3008
// 8-channel 10-bit ADC. Every SPI pin is oversampled in the clk domain
// (clk >= 8x SCLK); nothing is clocked by SCLK.
// Optional build macro: MCP3008_LSB_TAIL_EN -- after B0, repeat B1..B9
// LSB-first like the real part, then drive zeros. Undefined: zeros after B0.

// Per-pin synchronizer plus one edge-detect flop. Reset value is per pin so
// an idle-high csn does not produce a spurious edge when reset releases.
module adc_mcp3008_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic aclr_n,
  input  logic sclr,
  input  logic d,
  output logic q,
  output logic q_prev
);
  logic [STAGES-1:0] pipe;

  // Shift the pin through the synchronizer and keep the previous output.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      pipe   <= {STAGES{RST_VAL}};
      q_prev <= RST_VAL;
    end else if (sclr) begin
      pipe   <= {STAGES{RST_VAL}};
      q_prev <= RST_VAL;
    end else begin
      pipe   <= {pipe[STAGES-2:0], d};
      q_prev <= pipe[STAGES-1];
    end
  end

  assign q = pipe[STAGES-1];
endmodule

module adc_mcp3008_responder #(
  parameter int ADC_WIDTH   = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       aclr_n,
  input  logic                       sclr,
  input  logic                       sclk,
  input  logic                       csn,
  input  logic                       mosi,
  output logic                       miso,
  output logic                       miso_oe,
  input  logic [7:0][ADC_WIDTH-1:0]  ch,
  output logic                       cmd_valid,
  output logic                       cmd_sgl,
  output logic [2:0]                 cmd_ch,
  output logic                       frame_err
);
  localparam int          NPIN     = 3;           // 0: sclk, 1: csn, 2: mosi
  localparam logic [2:0]  SYNC_RST = 3'b010;      // csn idles high
  localparam logic [3:0]  LAST_BIT = 4'(ADC_WIDTH-1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_CMD, ST_SAMPLE, ST_NULL, ST_DATA, ST_TAIL
  } state_t;

  logic [NPIN-1:0] pin_raw, pin_q, pin_prev;
  logic            sclk_rise, sclk_fall, csn_rise, csn_fall, mosi_s;

  state_t          state;
  logic [3:0]      bit_cnt;
  logic [2:0]      cmd_sr;
  logic [ADC_WIDTH-1:0] data_sr;
  logic [ADC_WIDTH-1:0] result;
  logic [ADC_WIDTH:0]   a_ext, b_ext, diff;
`ifdef MCP3008_LSB_TAIL_EN
  logic [ADC_WIDTH-1:0] res_q;
`endif

  assign pin_raw = {mosi, csn, sclk};

  genvar gi;
  generate
    for (gi = 0; gi < NPIN; gi++) begin : g_sync
      adc_mcp3008_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (SYNC_RST[gi])
      ) u_sync (
        .clk    (clk),
        .aclr_n (aclr_n),
        .sclr   (sclr),
        .d      (pin_raw[gi]),
        .q      (pin_q[gi]),
        .q_prev (pin_prev[gi])
      );
    end
  endgenerate

  assign sclk_rise =  pin_q[0] & ~pin_prev[0];
  assign sclk_fall = ~pin_q[0] &  pin_prev[0];
  assign csn_rise  =  pin_q[1] & ~pin_prev[1];
  assign csn_fall  = ~pin_q[1] &  pin_prev[1];
  assign mosi_s    =  pin_q[2];

  // Conversion result for the last decoded command; differential modes
  // subtract one bit wider and clamp negative differences to zero.
  always_comb begin
    a_ext  = {1'b0, ch[{cmd_ch[2:1], 1'b0}]};
    b_ext  = {1'b0, ch[{cmd_ch[2:1], 1'b1}]};
    diff   = cmd_ch[0] ? (b_ext - a_ext) : (a_ext - b_ext);
    result = '0;
    if (cmd_sgl)
      result = ch[cmd_ch];
    else if (!diff[ADC_WIDTH])
      result = diff[ADC_WIDTH-1:0];
  end

  // Frame FSM: csn edges take priority, sclk edges advance the frame.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      data_sr   <= '0;
`ifdef MCP3008_LSB_TAIL_EN
      res_q     <= '0;
`endif
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_sgl   <= 1'b0;
      cmd_ch    <= '0;
      frame_err <= 1'b0;
    end else if (sclr) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      data_sr   <= '0;
`ifdef MCP3008_LSB_TAIL_EN
      res_q     <= '0;
`endif
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_sgl   <= 1'b0;
      cmd_ch    <= '0;
      frame_err <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      if (csn_rise) begin
        // Aborted before B0 was driven: flag it to the master side.
        frame_err <= (state == ST_CMD) || (state == ST_SAMPLE) ||
                     (state == ST_NULL) || (state == ST_DATA);
        state     <= ST_IDLE;
        miso      <= 1'b0;
        miso_oe   <= 1'b0;
      end else if (csn_fall) begin
        // Also covers a missed csn rise: restart the frame.
        state     <= ST_START;
        miso      <= 1'b0;
        miso_oe   <= 1'b0;
      end else begin
        case (state)
          ST_START: begin
            if (sclk_rise && mosi_s) begin
              state   <= ST_CMD;
              bit_cnt <= '0;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              cmd_sr  <= {cmd_sr[1:0], mosi_s};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd3) begin
                cmd_valid <= 1'b1;
                cmd_sgl   <= cmd_sr[2];
                cmd_ch    <= {cmd_sr[1:0], mosi_s};
                state     <= ST_SAMPLE;
              end
            end
          end
          ST_SAMPLE: begin
            if (sclk_fall) begin
              data_sr <= result;
`ifdef MCP3008_LSB_TAIL_EN
              res_q   <= result;
`endif
              state   <= ST_NULL;
            end
          end
          ST_NULL: begin
            if (sclk_fall) begin
              miso_oe <= 1'b1;
              miso    <= 1'b0;
              bit_cnt <= '0;
              state   <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (sclk_fall) begin
              miso    <= data_sr[ADC_WIDTH-1];
              data_sr <= {data_sr[ADC_WIDTH-2:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                state   <= ST_TAIL;
              end
            end
          end
          ST_TAIL: begin
            if (sclk_fall) begin
`ifdef MCP3008_LSB_TAIL_EN
              if (bit_cnt < LAST_BIT) begin
                miso    <= res_q[bit_cnt + 4'd1];
                bit_cnt <= bit_cnt + 4'd1;
              end else begin
                miso    <= 1'b0;
              end
`else
              miso <= 1'b0;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_adc_mcp3008_responder.sv
// Bench for adc_mcp3008_responder: an SPI master drives frames with SCLK at
// clk/16 and compares every received bit against a frame-level model of
// the MCP3008 protocol (null bit, MSB-first result, optional LSB tail).
module tb_adc_mcp3008_responder;
  logic clk = 1'b0, aclr_n = 1'b0, sclr = 1'b0;
  logic sclk = 1'b0, csn = 1'b1, mosi = 1'b0;
  logic miso, miso_oe, cmd_valid, cmd_sgl, frame_err;
  logic [2:0] cmd_ch;
  logic [7:0][9:0] ch_d;

  int tests = 0, fails = 0;
  int cyc = 0, cv_cnt = 0, fe_cnt = 0, cv_cyc = 0;
  logic cv_sgl = 1'b0;
  logic [2:0] cv_ch = '0;
  logic [63:0] rx, oe_v;
  int rise_cyc [64];

  adc_mcp3008_responder #(.ADC_WIDTH(10), .SYNC_STAGES(2)) dut (
    .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .sclk(sclk), .csn(csn),
    .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .ch(ch_d),
    .cmd_valid(cmd_valid), .cmd_sgl(cmd_sgl), .cmd_ch(cmd_ch),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitors sampled away from the active edge.
  always @(negedge clk) begin
    if (cmd_valid) begin
      cv_cnt = cv_cnt + 1;
      cv_cyc = cyc;
      cv_sgl = cmd_sgl;
      cv_ch  = cmd_ch;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
      $error("%s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic rand_ch();
    for (int i = 0; i < 8; i++) ch_d[i] = 10'($urandom);
  endtask

  // Reference conversion, straight from the MCP3008 channel table.
  function automatic int ref_res(input bit sgl, input bit [2:0] d);
    int p, a, b, v;
    if (sgl) return int'(ch_d[d]);
    p = int'(d) / 2;
    a = int'(ch_d[2*p]);
    b = int'(ch_d[2*p+1]);
    v = (d % 2 == 1) ? b - a : a - b;
    return (v < 0) ? 0 : v;
  endfunction

  // One master frame; rx/oe_v bit i holds miso/miso_oe seen on rise i+1.
  task automatic frame(input int nbits, input logic [63:0] tx,
                       input int scr_idx, input int rst_idx);
    bit stop;
    stop = 1'b0;
    rx = '0;
    oe_v = '0;
    @(negedge clk);
    csn = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits && !stop; i++) begin
      mosi = tx[i];
      repeat (8) @(negedge clk);
      sclk = 1'b1;
      rise_cyc[i] = cyc;
      rx[i] = miso;
      oe_v[i] = miso_oe;
      if (i == scr_idx) rand_ch();
      if (i == rst_idx) begin
        repeat (4) @(negedge clk);
        aclr_n = 1'b0;
        #1;
        check("rst_miso", 64'(miso), 64'(0));
        check("rst_oe", 64'(miso_oe), 64'(0));
        check("rst_cv", 64'(cmd_valid), 64'(0));
        check("rst_sgl", 64'(cmd_sgl), 64'(0));
        check("rst_ch", 64'(cmd_ch), 64'(0));
        check("rst_fe", 64'(frame_err), 64'(0));
        repeat (2) @(negedge clk);
        aclr_n = 1'b1;
        stop = 1'b1;
      end
      repeat (8) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    csn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("oe_after_csn", 64'(miso_oe), 64'(0));
    check("miso_after_csn", 64'(miso), 64'(0));
    repeat (12) @(negedge clk);
  endtask

  // Build, send and score one frame against the protocol model.
  task automatic run(input string tag, input int lead, input bit sgl,
                     input bit [2:0] d, input int nbits, input int scr_idx,
                     input int rst_idx, input int exp_fe, output int res_got);
    logic [63:0] tx, erx, eoe;
    int k, cv0, fe0, nchk, res, j, t;
    k = lead + 1;
    tx = {$urandom, $urandom};
    for (int i = 0; i < lead; i++) tx[i] = 1'b0;
    tx[lead]   = 1'b1;
    tx[lead+1] = sgl;
    tx[lead+2] = d[2];
    tx[lead+3] = d[1];
    tx[lead+4] = d[0];
    res = ref_res(sgl, d);
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    frame(nbits, tx, scr_idx, rst_idx);
    nchk = (rst_idx >= 0) ? rst_idx + 1 : nbits;
    erx = '0;
    eoe = '0;
    for (int i = 0; i < nchk; i++) begin
      j = i + 1;
      if (j >= k + 6) eoe[i] = 1'b1;
      if (j >= k + 7 && j <= k + 16) erx[i] = 1'((res >> (k + 16 - j)) & 1);
`ifdef MCP3008_LSB_TAIL_EN
      t = j - k - 17;
      if (j > k + 16 && t <= 8) erx[i] = 1'((res >> (t + 1)) & 1);
`else
      t = 0;
`endif
    end
    check({tag, "_miso"}, rx, erx);
    check({tag, "_oe"}, oe_v, eoe);
    check({tag, "_ferr"}, 64'(fe_cnt - fe0), 64'(exp_fe));
    check({tag, "_cvcnt"}, 64'(cv_cnt - cv0), 64'(1));
    check({tag, "_sgl"}, 64'(cv_sgl), 64'(sgl));
    check({tag, "_ch"}, 64'(cv_ch), 64'(d));
    check({tag, "_cvlat"}, 64'(cv_cyc - rise_cyc[k+3]), 64'(3));
    res_got = 0;
    for (int n = 0; n < 10; n++) res_got = (res_got << 1) | int'(rx[k + 6 + n]);
  endtask

  initial begin
    int r, r2;
    logic [7:0] byte2;
    logic [8:0] tailv;
    rand_ch();
    repeat (3) @(negedge clk);
    check("reset_miso", 64'(miso), 64'(0));
    check("reset_oe", 64'(miso_oe), 64'(0));
    check("reset_cv", 64'({cmd_valid, cmd_sgl, cmd_ch, frame_err}), 64'(0));
    aclr_n = 1'b1;
    repeat (4) @(negedge clk);
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    check("sclr_outs", 64'({miso, miso_oe, cmd_valid, cmd_sgl, cmd_ch, frame_err}), 64'(0));

    // Single-ended, 3-byte frame 01 D0 00.
    ch_d[5] = 10'h2A5;
    run("sgl5", 7, 1'b1, 3'd5, 24, -1, -1, 0, r);
    check("sgl5_res", 64'(r), 64'h2A5);
    check("sgl5_b1lo", 64'({rx[13], rx[14], rx[15]}), 64'(3'b010));
    byte2 = '0;
    for (int b = 0; b < 8; b++) byte2 = {byte2[6:0], rx[16 + b]};
    check("sgl5_b2", 64'(byte2), 64'hA5);

    // Differential pair 1, both polarities.
    ch_d[2] = 10'd300;
    ch_d[3] = 10'd100;
    run("diff010", 7, 1'b0, 3'b010, 24, -1, -1, 0, r);
    check("diff010_res", 64'(r), 64'd200);
    run("diff011", 7, 1'b0, 3'b011, 24, -1, -1, 0, r);
    check("diff011_res", 64'(r), 64'd0);

    // Leading zeros: 5 zero rises before the start bit.
    run("lead5", 5, 1'b1, 3'd5, 24, -1, -1, 0, r2);
    check("lead5_res", 64'(r2), 64'h2A5);

    // Abort after B5 (start bit on rise 8, B5 on rise 19).
    run("abort", 7, 1'b1, 3'd5, 19, -1, -1, 1, r);
    run("post_abort", 7, 1'b0, 3'b010, 24, -1, -1, 0, r);
    check("post_abort_res", 64'(r), 64'd200);

    // Tail: ch[0] = 0x301, long frame shows the repeat and the zeros after.
    ch_d[0] = 10'h301;
    run("tail", 7, 1'b1, 3'd0, 40, -1, -1, 0, r);
    tailv = '0;
    for (int b = 0; b < 9; b++) tailv = {tailv[7:0], rx[24 + b]};
`ifdef MCP3008_LSB_TAIL_EN
    check("tail_bits", 64'(tailv), 64'(9'b000000011));
`else
    check("tail_bits", 64'(tailv), 64'(0));
`endif
    check("tail_zero", 64'(rx[39:33]), 64'(0));

    // Async reset during DATA, then a clean frame.
    run("rstmid", 7, 1'b1, 3'd5, 24, -1, 18, 0, r);
    run("post_rst", 7, 1'b1, 3'd5, 24, -1, -1, 0, r);
    check("post_rst_res", 64'(r), 64'h2A5);

    // Randomized frames; ch is scrambled after the sample point.
    for (int n = 0; n < 20; n++) begin
      int lead, nb;
      bit sgl;
      bit [2:0] d;
      lead = int'($urandom_range(0, 5));
      sgl  = 1'($urandom);
      d    = 3'($urandom);
      nb   = lead + 1 + 16 + int'($urandom_range(0, 12));
      rand_ch();
      if (n % 4 == 0) ch_d[{d[2:1], 1'b0}] = 10'h3FF;
      if (n % 4 == 1) ch_d[{d[2:1], 1'b1}] = 10'h3FF;
      run("rnd", lead, sgl, d, nb, lead + 6, -1, 0, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
